// File: rtl/irrig_pkg.sv
// Shared irrigation types: valve-distributor state encoding and index-to-one-hot helper.
package irrig_pkg;

  localparam int NUM_VALVES = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    HOLD,
    ACTIVE
  } valve_state_e;

  function automatic logic [NUM_VALVES-1:0] onehot4(input logic [1:0] idx);
    logic [NUM_VALVES-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/valve_timer.sv
// Loadable down-counter that sticks at zero; done flags the end of the loaded interval.
module valve_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/valve_demux_ctrl.sv
// Routes one open/close command stream to four valves, one at a time, with
// break-before-make dead time and a minimum on-time after each opening.
module valve_demux_ctrl
  import irrig_pkg::*;
#(
  parameter int DEAD_CYCLES   = 4,
  parameter int MIN_ON_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_on,
  input  logic [1:0]            req_sel,
  output logic [NUM_VALVES-1:0] valve_out,
  output logic [1:0]            active_sel,
  output logic                  busy
);

  localparam int MAX_CYCLES = (DEAD_CYCLES > MIN_ON_CYCLES) ? DEAD_CYCLES : MIN_ON_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // Timer is loaded with N-1 so that the phase lasts exactly N cycles including the load cycle's successor.
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_ON_CYCLES - 1);

  valve_state_e          state_q, state_d;
  logic [NUM_VALVES-1:0] valve_q, valve_d;
  logic [1:0]            active_sel_q, active_sel_d;
  logic [1:0]            target_q, target_d;
  logic                  timer_load;
  logic [CNT_W-1:0]      timer_load_val;
  logic                  timer_done;
  logic                  accept;

  valve_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_load_val),
    .done     (timer_done)
  );

  assign req_ready  = rst_n && ((state_q == IDLE) || (state_q == ACTIVE));
  assign accept     = req_valid && req_ready;
  assign busy       = (state_q == DEAD) || (state_q == HOLD);
  assign valve_out  = valve_q;
  assign active_sel = active_sel_q;

  always_comb begin
    state_d        = state_q;
    valve_d        = valve_q;
    active_sel_d   = active_sel_q;
    target_d       = target_q;
    timer_load     = 1'b0;
    timer_load_val = '0;
    case (state_q)
      IDLE: begin
        if (accept && req_on) begin
          state_d        = DEAD;
          target_d       = req_sel;
          timer_load     = 1'b1;
          timer_load_val = DEAD_LOAD;
        end
      end
      DEAD: begin
        if (timer_done) begin
          state_d        = HOLD;
          valve_d        = onehot4(target_q);
          active_sel_d   = target_q;
          timer_load     = 1'b1;
          timer_load_val = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (timer_done) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // Reopening the valve already driven is a no-op; anything else closes all valves first.
        if (accept) begin
          if (!req_on) begin
            state_d      = IDLE;
            valve_d      = '0;
            active_sel_d = '0;
          end else if (req_sel != active_sel_q) begin
            state_d        = DEAD;
            valve_d        = '0;
            active_sel_d   = '0;
            target_d       = req_sel;
            timer_load     = 1'b1;
            timer_load_val = DEAD_LOAD;
          end
        end
      end
      default: begin
        state_d      = IDLE;
        valve_d      = '0;
        active_sel_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valve_q      <= '0;
      active_sel_q <= '0;
      target_q     <= '0;
    end else begin
      state_q      <= state_d;
      valve_q      <= valve_d;
      active_sel_q <= active_sel_d;
      target_q     <= target_d;
    end
  end

endmodule

// File: tb/tb_valve_demux_ctrl.sv
// Scoreboard bench for valve_demux_ctrl: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them and checks valve_out stays at most one-hot.
module tb_valve_demux_ctrl;

  localparam int DEAD  = 4;
  localparam int MINON = 8;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_on    = 1'b0;
  logic [1:0] req_sel   = 2'd0;
  logic       req_ready;
  logic [3:0] valve_out;
  logic [1:0] active_sel;
  logic       busy;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] valve;
    logic [1:0] asel;
    logic       ready;
    logic       busy;
    string      name;
  } exp_t;

  exp_t sb[$];

  valve_demux_ctrl #(
    .DEAD_CYCLES   (DEAD),
    .MIN_ON_CYCLES (MINON)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_on     (req_on),
    .req_sel    (req_sel),
    .valve_out  (valve_out),
    .active_sel (active_sel),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void push_exp(int c, logic [3:0] v, logic [1:0] a, logic r, logic b, string n);
    exp_t e;
    e.cyc   = c;
    e.valve = v;
    e.asel  = a;
    e.ready = r;
    e.busy  = b;
    e.name  = n;
    sb.push_back(e);
  endfunction

  // Open accepted at the end of cycle c: dead time, hold, then first ready cycle.
  function automatic void push_open(int c, logic [1:0] sel, logic [3:0] oh, string n);
    for (int i = 1; i <= DEAD; i++) push_exp(c + i, 4'b0000, 2'd0, 1'b0, 1'b1, {n, "_dead"});
    for (int i = DEAD + 1; i <= DEAD + MINON; i++) push_exp(c + i, oh, sel, 1'b0, 1'b1, {n, "_hold"});
    push_exp(c + DEAD + MINON + 1, oh, sel, 1'b1, 1'b0, {n, "_active"});
  endfunction

  initial forever begin
    @(negedge clk);
    if (cyc >= 1) begin
      total++;
      if ($countones(valve_out) > 1) begin
        bad++;
        $display("[TB] FAIL onehot cyc=%0d valve_out=%b required popcount<=1", cyc, valve_out);
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        total++;
        if (sb[i].cyc != cyc ||
            {valve_out, active_sel, req_ready, busy} !== {sb[i].valve, sb[i].asel, sb[i].ready, sb[i].busy}) begin
          bad++;
          $display("[TB] FAIL %s cyc=%0d/%0d got valve=%b sel=%0d ready=%b busy=%b want valve=%b sel=%0d ready=%b busy=%b",
                   sb[i].name, cyc, sb[i].cyc, valve_out, active_sel, req_ready, busy,
                   sb[i].valve, sb[i].asel, sb[i].ready, sb[i].busy);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic on, input logic [1:0] s);
    req_valid = v;
    req_on    = on;
    req_sel   = s;
  endtask

  task automatic open_cmd(input logic [1:0] sel, input logic [3:0] oh, input string n);
    drive(1'b1, 1'b1, sel);
    push_open(cyc, sel, oh, n);
    step(1);
    drive(1'b0, 1'b0, 2'd0);
    step(DEAD + MINON);
  endtask

  task automatic apply_stimulus();
    int c;
    // Reset held three edges with a pending open that must not be taken.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 2'd2);
    push_exp(1, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_c1");
    push_exp(2, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_c2");
    step(3);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 2'd0);
    push_exp(3, 4'b0000, 2'd0, 1'b1, 1'b0, "rst_release");
    push_exp(4, 4'b0000, 2'd0, 1'b1, 1'b0, "rst_no_accept_a");
    push_exp(5, 4'b0000, 2'd0, 1'b1, 1'b0, "rst_no_accept_b");
    step(2);

    open_cmd(2'd2, 4'b0100, "open2");
    open_cmd(2'd0, 4'b0001, "switch0");
    open_cmd(2'd1, 4'b0010, "switch1");

    drive(1'b1, 1'b1, 2'd1);
    push_exp(cyc + 1, 4'b0010, 2'd1, 1'b1, 1'b0, "same1_a");
    push_exp(cyc + 2, 4'b0010, 2'd1, 1'b1, 1'b0, "same1_b");
    step(1);
    drive(1'b0, 1'b0, 2'd0);
    step(1);

    drive(1'b1, 1'b0, 2'd2);
    push_exp(cyc + 1, 4'b0000, 2'd0, 1'b1, 1'b0, "close_a");
    push_exp(cyc + 2, 4'b0000, 2'd0, 1'b1, 1'b0, "close_b");
    step(1);
    drive(1'b0, 1'b0, 2'd0);
    step(1);

    drive(1'b1, 1'b0, 2'd3);
    push_exp(cyc + 1, 4'b0000, 2'd0, 1'b1, 1'b0, "idle_close_a");
    push_exp(cyc + 2, 4'b0000, 2'd0, 1'b1, 1'b0, "idle_close_b");
    step(1);
    drive(1'b0, 1'b0, 2'd0);
    step(1);

    // Second open held valid through the hold phase; taken only in the first ACTIVE cycle.
    c = cyc;
    drive(1'b1, 1'b1, 2'd3);
    push_open(c, 2'd3, 4'b1000, "open3");
    step(1);
    drive(1'b1, 1'b1, 2'd0);
    step(DEAD + MINON);
    push_open(c + DEAD + MINON + 1, 2'd0, 4'b0001, "queued0");
    step(1);
    drive(1'b0, 1'b0, 2'd0);
    step(DEAD + MINON);

    drive(1'b1, 1'b0, 2'd0);
    push_exp(cyc + 1, 4'b0000, 2'd0, 1'b1, 1'b0, "close0");
    step(1);
    drive(1'b0, 1'b0, 2'd0);
    step(1);

    // One-cycle reset in the middle of HOLD with valve 3 open.
    c = cyc;
    drive(1'b1, 1'b1, 2'd3);
    for (int i = 1; i <= DEAD; i++) push_exp(c + i, 4'b0000, 2'd0, 1'b0, 1'b1, "hrst_dead");
    push_exp(c + DEAD + 1, 4'b1000, 2'd3, 1'b0, 1'b1, "hrst_hold_a");
    push_exp(c + DEAD + 2, 4'b1000, 2'd3, 1'b0, 1'b1, "hrst_hold_b");
    step(1);
    drive(1'b0, 1'b0, 2'd0);
    step(DEAD + 1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    for (int i = DEAD + 3; i <= DEAD + 16; i++) push_exp(c + i, 4'b0000, 2'd0, 1'b1, 1'b0, "hrst_after");
    step(15);
  endtask

  initial begin
    apply_stimulus();
    step(2);
    while (sb.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unchecked %s cyc=%0d never sampled", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/valve_demux_ctrl.md
# valve_demux_ctrl

Valve distributor for the irrigation system: routes one open/close command stream to four valve outputs (1-to-4 demultiplex, the sink-side counterpart of the 4-to-1 input selector). It guarantees at most one valve is driven at a time, inserts a break-before-make dead time on every open request, and holds a newly opened valve for a minimum on-time before it accepts another command. It sits between the irrigation control FSM (command source) and the valve driver pins.

## Interface
- `DEAD_CYCLES`, 4, cycles with all valves off before any valve opens (>=1)
- `MIN_ON_CYCLES`, 8, minimum cycles a newly opened valve is held before new commands are accepted (>=1)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset; synchronous and active-low
- `req_valid`  in  1  command present
- `req_ready`  out  1  block accepts a command this cycle
- `req_on`  in  1  1 = open valve `req_sel`, 0 = close all valves
- `req_sel`  in  2  target valve index 0..3
- `valve_out`  out  4  one-hot valve drive, bit i = valve i open; all-zero = all closed
- `active_sel`  out  2  index of the open valve; 0 when none open
- `busy`  out  1  high in DEAD or HOLD

## Operation
- Command accepted on a rising edge with `req_valid && req_ready && rst_n`; `req_on`/`req_sel` sampled at that edge only.
- States: IDLE (all closed, ready=1), DEAD (all closed, ready=0), HOLD (valve open, ready=0), ACTIVE (valve open, ready=1).
- IDLE + accept on -> DEAD, latch target; open from IDLE also takes dead time.
- IDLE + accept off -> stay IDLE, no output change.
- DEAD: down-counter runs DEAD_CYCLES cycles, then -> HOLD with `valve_out` = one-hot(target).
- HOLD: counter runs MIN_ON_CYCLES cycles, then -> ACTIVE.
- ACTIVE + accept on, same sel -> stay ACTIVE, no change, no dead time.
- ACTIVE + accept on, different sel -> DEAD, `valve_out` = 0 next cycle, new target latched.
- ACTIVE + accept off -> IDLE, `valve_out` = 0 next cycle.
- `valve_out` is registered; never more than one bit set in any cycle, including transitions.
- Counter width = $clog2(max(DEAD_CYCLES, MIN_ON_CYCLES)+1); no wrap, saturates at 0.
- `req_ready` is combinational from state, forced 0 while `rst_n` low.
- `req_valid` high with `req_ready` low: command waits, not dropped or queued.

## Timing
- Reset (rst_n low at an edge): state IDLE, `valve_out`=0, `active_sel`=0, `busy`=0, counter 0; `req_ready`=0 while rst_n low, 1 on first cycle after release.
- Reset mid-DEAD/HOLD/ACTIVE: outputs go to reset values at that edge; pending target discarded.
- Open accepted at edge k: `valve_out`=0 cycles k+1..k+DEAD_CYCLES; valve high from k+DEAD_CYCLES+1; `req_ready`=0 k+1..k+DEAD_CYCLES+MIN_ON_CYCLES; `req_ready`=1 at k+DEAD_CYCLES+MIN_ON_CYCLES+1.
- Close accepted at edge k in ACTIVE: `valve_out`=0 at k+1, `req_ready` stays 1.
- `active_sel` updates in the same cycle as `valve_out`.

## Structure
- Shared package `irrig_pkg`: state enum (IDLE, DEAD, HOLD, ACTIVE), valve-count constant (4), `onehot4` function for 2-bit index to 4-bit one-hot.
- Sub-module `valve_timer`: loadable saturating down-counter with `load`, `load_val`, `done`; one instance serves both DEAD and HOLD phases.

## Test plan
All with DEAD_CYCLES=4, MIN_ON_CYCLES=8.
- Reset: rst_n low 3 cycles with req_valid=1 -> `valve_out`=0, `req_ready`=0, `busy`=0; after release `req_ready`=1, no command accepted during reset.
- IDLE, open sel=2 accepted at edge k -> `valve_out`=0000 k+1..k+4, 0100 at k+5, `active_sel`=2; `req_ready`=0 k+1..k+12, 1 at k+13.
- ACTIVE sel=2, open sel=0 -> 0000 for exactly 4 cycles then 0001; checker asserts popcount(`valve_out`)<=1 every cycle.
- ACTIVE sel=1, open sel=1 -> accepted, `valve_out` stays 0010, `req_ready` stays 1; then close -> 0000 next cycle, IDLE.
- Open sel=3 with req_valid held through HOLD for a second open sel=0 -> second command accepted only at first ACTIVE cycle, then normal DEAD/HOLD sequence to 0001.
- rst_n low for 1 cycle during HOLD (valve 3 open) -> `valve_out`=0, `busy`=0 next cycle; no valve opens afterwards without a new command.
